freq_counter_scheduler: RTL and testbench

Round-robin measurement scheduler for the frequency counter core. It holds a per-channel gate period and enable table, sequences the core across up to `CHANNELS` input pins, and discards the first (partial-gate) result after every period reload. It returns one qualified count per channel visit, with a timeout flag. It sits between the logic-analyser configuration bits and the counter core inside the project wrapper.

---
 rtl/freq_counter_pkg.sv | 15 +
 rtl/freq_counter_scheduler_rr_pick.sv | 30 +++
 rtl/freq_counter_scheduler.sv | 119 +++++++++++
 tb/tb_freq_counter_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency counter core and its measurement scheduler.
package freq_counter_pkg;

  localparam int FC_PERIOD_W = 12;
  localparam int FC_COUNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_MEASURE,
    S_REPORT
  } fc_state_e;

endpackage

// File: rtl/freq_counter_scheduler_rr_pick.sv
// Round-robin finder: first enabled channel strictly after last_chan, wrapping,
// with last_chan itself as the final candidate.
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] en,
  input  logic [CH_W-1:0]     last_chan,
  output logic                any,
  output logic [CH_W-1:0]     next
);

  always_comb begin
    logic            found;
    logic [CH_W-1:0] cand;
    any   = |en;
    next  = last_chan;
    found = 1'b0;
    cand  = '0;
    // CHANNELS is a power of two, so the CH_W-bit add wraps naturally.
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = last_chan + CH_W'(i);
      if (!found && en[cand]) begin
        next  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_counter_scheduler.sv
// Round-robin measurement scheduler: sequences the counter core over enabled
// channels, drops the partial first gate after each reload, reports one count per visit.
module freq_counter_scheduler
  import freq_counter_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CH_W      = $clog2(CHANNELS),
  parameter int PERIOD_W  = FC_PERIOD_W,
  parameter int COUNT_W   = FC_COUNT_W,
  parameter int TIMEOUT_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [CH_W-1:0]     core_sel,
  output logic [PERIOD_W-1:0] core_period,
  output logic                core_period_load,
  input  logic                core_done,
  input  logic [COUNT_W-1:0]  core_count,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_chan,
  output logic [COUNT_W-1:0]  res_count,
  output logic                res_timeout,
  output logic                busy
);

  localparam logic [CH_W-1:0] LAST_RST = CH_W'(CHANNELS - 1);

  fc_state_e                         state_q, state_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0] tbl_q;
  logic [CHANNELS-1:0]               chan_en;
  logic [CH_W-1:0]                   last_chan_q, pick_next;
  logic                              pick_any, timeout_d, wait_max;
  logic [TIMEOUT_W-1:0]              wait_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_en
    assign chan_en[c] = |tbl_q[c];
  end

  rr_pick #(.CHANNELS(CHANNELS), .CH_W(CH_W)) u_pick (
    .en        (chan_en),
    .last_chan (last_chan_q),
    .any       (pick_any),
    .next      (pick_next)
  );

  assign wait_max = &wait_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // core_done beats the timeout when both land in the same cycle.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE:    if (run && pick_any) state_d = S_LOAD;
      S_LOAD:    state_d = S_DISCARD;
      S_DISCARD: begin
        if (core_done)     state_d = S_MEASURE;
        else if (wait_max) begin
          state_d   = S_REPORT;
          timeout_d = 1'b1;
        end
      end
      S_MEASURE: begin
        if (core_done)     state_d = S_REPORT;
        else if (wait_max) begin
          state_d   = S_REPORT;
          timeout_d = 1'b1;
        end
      end
      S_REPORT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_q       <= '0;
      last_chan_q <= LAST_RST;
      core_sel    <= '0;
      core_period <= '0;
      wait_q      <= '0;
      res_chan    <= '0;
      res_count   <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (cfg_we) tbl_q[cfg_chan] <= cfg_period;
      // Table is read before this cycle's write lands, so a racing write is seen next visit.
      if (state_q == S_IDLE && state_d == S_LOAD) begin
        core_sel    <= pick_next;
        core_period <= tbl_q[pick_next];
      end
      case (state_q)
        S_LOAD:    wait_q <= '0;
        S_DISCARD: wait_q <= core_done ? '0 : wait_q + TIMEOUT_W'(1);
        S_MEASURE: wait_q <= wait_q + TIMEOUT_W'(1);
        default:   ;
      endcase
      if (state_d == S_REPORT) begin
        res_chan    <= core_sel;
        res_timeout <= timeout_d;
        res_count   <= timeout_d ? '0 : core_count;
      end
      if (state_q == S_REPORT) last_chan_q <= core_sel;
    end
  end

  assign core_period_load = (state_q == S_LOAD);
  assign res_valid        = (state_q == S_REPORT);
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_counter_scheduler.sv
// Directed bench: a small core model answers each period load; expected results are
// queued as visits are set up and popped when res_valid appears.
module tb_freq_counter_scheduler;

  localparam int CHANNELS  = 4;
  localparam int CH_W      = 2;
  localparam int PERIOD_W  = 12;
  localparam int COUNT_W   = 16;
  localparam int TIMEOUT_W = 4;

  logic                clk = 1'b0;
  logic                reset, run, cfg_we;
  logic [CH_W-1:0]     cfg_chan;
  logic [PERIOD_W-1:0] cfg_period;
  logic [CH_W-1:0]     core_sel;
  logic [PERIOD_W-1:0] core_period;
  logic                core_period_load;
  logic                core_done;
  logic [COUNT_W-1:0]  core_count;
  logic                res_valid;
  logic [CH_W-1:0]     res_chan;
  logic [COUNT_W-1:0]  res_count;
  logic                res_timeout;
  logic                busy;

  freq_counter_scheduler #(
    .CHANNELS(CHANNELS), .CH_W(CH_W), .PERIOD_W(PERIOD_W),
    .COUNT_W(COUNT_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_period(cfg_period),
    .core_sel(core_sel), .core_period(core_period), .core_period_load(core_period_load),
    .core_done(core_done), .core_count(core_count),
    .res_valid(res_valid), .res_chan(res_chan), .res_count(res_count),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: after a load, done with count 7 after m_gap1 cycles (the discarded
  // gate), then done with m_base+core_sel after m_gap2 more. m_mode 1 = never done.
  int m_gap1 = 1, m_gap2 = 1, m_base = 0, m_mode = 0;
  int m_phase = 0, m_cnt = 0, m_done2_cyc = -1;
  always @(negedge clk) begin
    core_done = 1'b0;
    if (reset) begin
      m_phase = 0;
    end else if (core_period_load) begin
      m_phase = 1;
      m_cnt   = 0;
    end else if (m_phase == 1) begin
      m_cnt++;
      if (m_mode == 0 && m_cnt == m_gap1) begin
        core_done  = 1'b1;
        core_count = 16'd7;
        m_phase    = 2;
        m_cnt      = 0;
      end
    end else if (m_phase == 2) begin
      m_cnt++;
      if (m_cnt == m_gap2) begin
        core_done   = 1'b1;
        core_count  = COUNT_W'(m_base + int'(core_sel));
        m_done2_cyc = cyc;
        m_phase     = 0;
      end
    end
  end

  typedef struct {
    logic [CH_W-1:0]     chan;
    logic [COUNT_W-1:0]  count;
    logic                tmo;
    logic [PERIOD_W-1:0] period;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic cfg(input int ch, input int p);
    cfg_we = 1'b1; cfg_chan = CH_W'(ch); cfg_period = PERIOD_W'(p);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic push(input int ch, input int cnt, input bit tmo, input int p);
    exp_t e;
    e.chan = CH_W'(ch); e.count = COUNT_W'(cnt); e.tmo = tmo; e.period = PERIOD_W'(p);
    exp_q.push_back(e);
  endtask

  task automatic wait_load(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick(1);
      seen = core_period_load;
    end
    chk({tag, ".load_seen"}, 32'(seen), 32'd1);
  endtask

  // Waits for one result, checks it against the queue head, plus the load it saw.
  task automatic run_visit(input string tag, input bit chk_ld, input int budget);
    exp_t e;
    bit seen_res = 1'b0;
    int ld_n = 0, ld_cyc = 0, res_cyc = 0;
    logic [CH_W-1:0]     ld_sel = '0;
    logic [PERIOD_W-1:0] ld_per = '0;
    e = exp_q.pop_front();
    for (int k = 0; k < budget && !seen_res; k++) begin
      tick(1);
      if (core_period_load) begin
        ld_n++; ld_sel = core_sel; ld_per = core_period; ld_cyc = cyc;
      end
      if (res_valid) begin
        seen_res = 1'b1;
        res_cyc  = cyc;
      end
    end
    chk({tag, ".res_seen"}, 32'(seen_res), 32'd1);
    if (seen_res) begin
      chk({tag, ".res_chan"}, 32'(res_chan), 32'(e.chan));
      chk({tag, ".res_count"}, 32'(res_count), 32'(e.count));
      chk({tag, ".res_timeout"}, 32'(res_timeout), 32'(e.tmo));
      // Timeout with no done at all: REPORT 17 cycles after LOAD (16 DISCARD cycles).
      if (e.tmo) chk({tag, ".tmo_latency"}, 32'(res_cyc - ld_cyc), 32'd17);
      else       chk({tag, ".done_latency"}, 32'(res_cyc), 32'(m_done2_cyc + 1));
    end
    if (chk_ld) begin
      chk({tag, ".load_count"}, 32'(ld_n), 32'd1);
      chk({tag, ".core_sel"}, 32'(ld_sel), 32'(e.chan));
      chk({tag, ".core_period"}, 32'(ld_per), 32'(e.period));
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_chan = '0; cfg_period = '0;
    core_done = 1'b0; core_count = '0;
    tick(3);
    chk("rst.core_sel", 32'(core_sel), 0);
    chk("rst.core_period", 32'(core_period), 0);
    chk("rst.load", 32'(core_period_load), 0);
    chk("rst.res_valid", 32'(res_valid), 0);
    chk("rst.res_chan", 32'(res_chan), 0);
    chk("rst.res_count", 32'(res_count), 0);
    chk("rst.res_timeout", 32'(res_timeout), 0);
    chk("rst.busy", 32'(busy), 0);
    reset = 1'b0;
    run = 1'b1;
    tick(3);
    chk("empty_table.busy", 32'(busy), 0);
    run = 1'b0;

    // Single channel: discarded count 7, measured 55.
    m_gap1 = 3; m_gap2 = 4; m_base = 53; m_mode = 0;
    cfg(2, 100);
    push(2, 55, 1'b0, 100);
    run = 1'b1;
    run_visit("single", 1'b1, 40);
    run = 1'b0;
    tick(2);
    chk("single.idle_busy", 32'(busy), 0);

    // Round-robin over 0,1,3 with 2 disabled.
    do_reset();
    m_gap1 = 2; m_gap2 = 3; m_base = 100;
    cfg(0, 10); cfg(1, 20); cfg(3, 30); cfg(2, 0);
    push(0, 100, 1'b0, 10); push(1, 101, 1'b0, 20); push(3, 103, 1'b0, 30);
    push(0, 100, 1'b0, 10); push(1, 101, 1'b0, 20);
    run = 1'b1;
    for (int v = 0; v < 5; v++) run_visit($sformatf("rr%0d", v), 1'b1, 40);
    run = 1'b0;
    tick(2);

    // Config race: write lands in the same cycle IDLE latches channel 0.
    do_reset();
    m_base = 40;
    cfg(0, 100);
    run = 1'b1; cfg_we = 1'b1; cfg_chan = 2'd0; cfg_period = 12'd200;
    tick(1);
    cfg_we = 1'b0;
    chk("race.load", 32'(core_period_load), 1);
    chk("race.old_period", 32'(core_period), 100);
    push(0, 40, 1'b0, 100);
    run_visit("race1", 1'b0, 40);
    push(0, 40, 1'b0, 200);
    run_visit("race2", 1'b1, 40);
    run = 1'b0;
    tick(2);

    // Timeout: channel 1 enabled, core never reports.
    do_reset();
    m_mode = 1;
    cfg(1, 50);
    push(1, 0, 1'b1, 50);
    run = 1'b1;
    run_visit("timeout", 1'b1, 40);
    run = 1'b0;
    m_mode = 0;
    tick(2);

    // Done lands exactly as the MEASURE wait counter reaches all-ones.
    m_gap1 = 2; m_gap2 = 16; m_base = 8;
    push(1, 9, 1'b0, 50);
    run = 1'b1;
    run_visit("collide", 1'b1, 40);
    run = 1'b0;
    tick(2);

    // Run dropped during DISCARD: visit still completes, then idle.
    m_gap1 = 6; m_gap2 = 3; m_base = 20;
    push(1, 21, 1'b0, 50);
    run = 1'b1;
    wait_load("drop", 10);
    tick(1);
    run = 1'b0;
    run_visit("drop", 1'b0, 40);
    tick(2);
    chk("drop.busy", 32'(busy), 0);
    chk("drop.hold_chan", 32'(res_chan), 1);
    chk("drop.hold_count", 32'(res_count), 21);

    // Reset during MEASURE clears everything, including the table.
    m_gap1 = 2; m_gap2 = 10;
    run = 1'b1;
    wait_load("mrst", 10);
    tick(4);
    chk("mrst.in_measure", 32'(busy), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mrst.core_sel", 32'(core_sel), 0);
    chk("mrst.core_period", 32'(core_period), 0);
    chk("mrst.load", 32'(core_period_load), 0);
    chk("mrst.res_valid", 32'(res_valid), 0);
    chk("mrst.res_chan", 32'(res_chan), 0);
    chk("mrst.res_count", 32'(res_count), 0);
    chk("mrst.res_timeout", 32'(res_timeout), 0);
    chk("mrst.busy", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk($sformatf("mrst.cleared_busy%0d", k), 32'(busy), 0);
    end
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
